// File: rtl/psk_symbol_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : psk_symbol_packer_if
// Brief    : FIFO-side and mapper-side signals of the PSK symbol packer.
// Revision : 1.0 - initial release
// ============================================================================
interface psk_symbol_packer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int BITS_PER_SYM = 2
);
    logic                    enable;
    logic [DATA_WIDTH-1:0]   fifo_data;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic                    sym_tick;
    logic [BITS_PER_SYM-1:0] sym_out;
    logic                    sym_valid;
    logic                    underrun;
    logic                    busy;

    // master: the packer itself; slave: FIFO, tick source and phase mapper
    modport master (
        input  enable, fifo_data, fifo_empty, sym_tick,
        output fifo_rd_en, sym_out, sym_valid, underrun, busy
    );

    modport slave (
        output enable, fifo_data, fifo_empty, sym_tick,
        input  fifo_rd_en, sym_out, sym_valid, underrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/psk_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module   : psk_symbol_packer
// Brief    : Slices FWFT FIFO words into (optionally Gray-coded) PSK symbols.
// Revision : 1.0 - initial release
// ============================================================================
module psk_symbol_packer #(
    parameter int                      DATA_WIDTH   = 8,
    parameter int                      BITS_PER_SYM = 2,
    parameter int                      GRAY_EN      = 1,
    parameter int                      MSB_FIRST    = 1,
    parameter logic [BITS_PER_SYM-1:0] IDLE_SYM     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    psk_symbol_packer_if.master bus
);
    localparam int                 c_nsym     = DATA_WIDTH / BITS_PER_SYM;
    localparam int                 c_cnt_w    = $clog2(c_nsym + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_nsym[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_cnt_one  = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [BITS_PER_SYM-1:0] r_sym_out;
    logic                    r_sym_valid;
    logic                    r_underrun;
    logic                    r_busy;

    logic [DATA_WIDTH-1:0]   w_shreg_shifted;
    logic [BITS_PER_SYM-1:0] w_slice;
    logic [BITS_PER_SYM-1:0] w_sym;
    logic                    w_cnt_zero;
    logic                    w_pop;

    assign w_cnt_zero = (r_cnt == '0);

    // Popping on the last symbol's tick keeps consecutive words gap-free
    assign w_pop = rst_n & bus.enable & ~bus.fifo_empty
                 & (w_cnt_zero | ((r_cnt == c_cnt_one) & bus.sym_tick));

    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_slice         = r_shreg[DATA_WIDTH-1 -: BITS_PER_SYM];
        assign w_shreg_shifted = r_shreg << BITS_PER_SYM;
    end else begin : g_lsb_first
        assign w_slice         = r_shreg[BITS_PER_SYM-1:0];
        assign w_shreg_shifted = r_shreg >> BITS_PER_SYM;
    end

    if (GRAY_EN != 0) begin : g_gray
        assign w_sym = w_slice ^ (w_slice >> 1);
    end else begin : g_binary
        assign w_sym = w_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_sym_out   <= '0;
            r_sym_valid <= 1'b0;
            r_underrun  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sym_valid <= 1'b0;
            r_underrun  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shreg <= bus.fifo_data;
                        r_cnt   <= c_cnt_full;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.sym_tick) begin
                        if (!w_cnt_zero) begin
                            r_sym_out   <= w_sym;
                            r_sym_valid <= 1'b1;
                            r_shreg     <= w_shreg_shifted;
                            r_cnt       <= r_cnt - c_cnt_one;
                        end else if (bus.enable) begin
                            r_sym_out   <= IDLE_SYM;
                            r_sym_valid <= 1'b1;
                            r_underrun  <= 1'b1;
                        end
                    end
                    // A pop overrides the shift/decrement of the same edge
                    if (w_pop) begin
                        r_shreg <= bus.fifo_data;
                        r_cnt   <= c_cnt_full;
                    end
                    if (!bus.enable && w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = w_pop;
    assign bus.sym_out    = r_sym_out;
    assign bus.sym_valid  = r_sym_valid;
    assign bus.underrun   = r_underrun;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire
